stack_unit: RTL and testbench

- Sequences 8086-style word PUSH/POP for the execution unit.
- Reads SP and the source value from the general/pointer register file, and runs a req/ack stack memory transaction.
- Drives the register file write port (en_write, data_in, select_data_h_reg) to update SP and, for POP, the destination register.
- Sits directly upstream of the register file's write port; the writeback mux gives it ownership while busy=1.

---
 rtl/stack_unit_pkg.sv | 29 ++
 rtl/stack_unit_timeout_ctr.sv | 39 +++
 rtl/stack_unit.sv | 183 ++++++++++++++++++
 tb/tb_stack_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_unit_pkg.sv
// Shared definitions for the 8086-style PUSH/POP sequencer.
// Word register indices follow the register file's write-enable bit order.
package stack_unit_pkg;

  localparam logic [2:0] REG_AX = 3'd0;
  localparam logic [2:0] REG_BX = 3'd1;
  localparam logic [2:0] REG_CX = 3'd2;
  localparam logic [2:0] REG_DX = 3'd3;
  localparam logic [2:0] REG_SI = 3'd4;
  localparam logic [2:0] REG_DI = 3'd5;
  localparam logic [2:0] REG_SP = 3'd6;
  localparam logic [2:0] REG_BP = 3'd7;

  localparam int EN_SP_BIT = 6;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam logic [15:0] STACK_STEP = 16'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM,
    ST_WB_REG,
    ST_WB_SP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/stack_unit_timeout_ctr.sv
// Loadable down-counter that bounds how long the stack waits for mem_ack.
// expired is high during the last permitted wait cycle.
module stack_timeout_ctr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == WIDTH'(1));

endmodule

// File: rtl/stack_unit.sv
// PUSH/POP sequencer: one stack memory transfer, then register file writeback
// of the destination register (POP) and the updated SP, with registered outputs.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [2:0]  reg_sel,
  input  logic [15:0] push_data,
  input  logic [15:0] sp_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] en_write,
  output logic [15:0] data_in,
  output logic        select_data_h_reg,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [2:0]  reg_q, reg_d;
  logic [15:0] data_q, data_d;
  logic [15:0] sp_q, sp_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] en_write_q, en_write_d;
  logic [15:0] data_in_q, data_in_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ctr_clear, ctr_load, ctr_enable, ctr_expired;

  stack_timeout_ctr #(.WIDTH(16)) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .clear      (ctr_clear),
    .load       (ctr_load),
    .load_value (16'(TIMEOUT_CYCLES)),
    .enable     (ctr_enable),
    .expired    (ctr_expired)
  );

  // Outputs are computed from the next state so every port comes straight off a flop.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    reg_d       = reg_q;
    data_d      = data_q;
    sp_d        = sp_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = 16'h0000;
    mem_wdata_d = 16'h0000;
    en_write_d  = 16'h0000;
    data_in_d   = 16'h0000;
    err_d       = 1'b0;
    ctr_clear   = 1'b0;
    ctr_load    = 1'b0;
    ctr_enable  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d        = op;
          reg_d       = reg_sel;
          data_d      = push_data;
          sp_d        = sp_in;
          state_d     = ST_MEM;
          ctr_load    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = (op == OP_PUSH);
          mem_addr_d  = (op == OP_PUSH) ? (sp_in - STACK_STEP) : sp_in;
          // PUSH SP stores the already-decremented SP, as the 8086 does.
          if (op == OP_PUSH) begin
            mem_wdata_d = (reg_sel == REG_SP) ? (sp_in - STACK_STEP) : push_data;
          end
        end
      end

      ST_MEM: begin
        if (mem_ack) begin
          ctr_clear = 1'b1;
          if (op_q == OP_PUSH) begin
            state_d               = ST_WB_SP;
            en_write_d[EN_SP_BIT] = 1'b1;
            data_in_d             = sp_q - STACK_STEP;
          end else begin
            state_d             = ST_WB_REG;
            en_write_d[reg_q]   = 1'b1;
            data_in_d           = mem_rdata;
          end
        end else if (ctr_expired) begin
          ctr_clear = 1'b1;
          state_d   = ST_DONE;
          err_d     = 1'b1;
        end else begin
          ctr_enable  = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = mem_we_q;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = mem_wdata_q;
        end
      end

      ST_WB_REG: begin
        if (reg_q == REG_SP) begin
          state_d = ST_DONE;
        end else begin
          state_d               = ST_WB_SP;
          en_write_d[EN_SP_BIT] = 1'b1;
          data_in_d             = sp_q + STACK_STEP;
        end
      end

      ST_WB_SP: state_d = ST_DONE;

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= 1'b0;
      reg_q       <= 3'd0;
      data_q      <= 16'h0000;
      sp_q        <= 16'h0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      en_write_q  <= 16'h0000;
      data_in_q   <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
      sp_q        <= sp_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      en_write_q  <= en_write_d;
      data_in_q   <= data_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign en_write          = en_write_q;
  assign data_in           = data_in_q;
  assign select_data_h_reg = 1'b0;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: a transaction-level model predicts every cycle's outputs,
// and a few directed scenarios pin literal values from the worked examples.
module tb_stack_unit;

  localparam int TO = 4;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] en;
    logic [15:0] din;
    logic        selh;
    logic        busy;
    logic        done;
    logic        err;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [2:0]  reg_sel;
  logic [15:0] push_data;
  logic [15:0] sp_in;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] en_write;
  logic [15:0] data_in;
  logic        select_data_h_reg;
  logic        busy;
  logic        done;
  logic        err;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  obs_t exp_q[$];
  obs_t hist[0:8191];

  stack_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .op                (op),
    .reg_sel           (reg_sel),
    .push_data         (push_data),
    .sp_in             (sp_in),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_ack           (mem_ack),
    .mem_rdata         (mem_rdata),
    .en_write          (en_write),
    .data_in           (data_in),
    .select_data_h_reg (select_data_h_reg),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t s;
    s.req   = mem_req;
    s.we    = mem_we;
    s.addr  = mem_addr;
    s.wdata = mem_wdata;
    s.en    = en_write;
    s.din   = data_in;
    s.selh  = select_data_h_reg;
    s.busy  = busy;
    s.done  = done;
    s.err   = err;
    return s;
  endfunction

  // Transaction model: w is the number of ack-less MEM cycles; w >= TO means no ack ever.
  function automatic void buildTrace(input logic o, input logic [2:0] r, input logic [15:0] d,
                                     input logic [15:0] sp, input int w, input logic [15:0] rd);
    obs_t e;
    obs_t m;
    m       = '0;
    m.req   = 1'b1;
    m.busy  = 1'b1;
    m.we    = (o == 1'b0);
    m.addr  = (o == 1'b0) ? sp - 16'd2 : sp;
    m.wdata = (o == 1'b0) ? ((r == 3'd6) ? sp - 16'd2 : d) : 16'h0000;
    exp_q.push_back('0);
    if (w >= TO) begin
      for (int i = 0; i < TO; i++) exp_q.push_back(m);
      e = '0; e.busy = 1'b1; e.done = 1'b1; e.err = 1'b1;
      exp_q.push_back(e);
      return;
    end
    for (int i = 0; i <= w; i++) exp_q.push_back(m);
    if (o == 1'b0) begin
      e = '0; e.busy = 1'b1; e.en = 16'h0040; e.din = sp - 16'd2;
      exp_q.push_back(e);
    end else begin
      e = '0; e.busy = 1'b1; e.en = 16'(1 << r); e.din = rd;
      exp_q.push_back(e);
      if (r != 3'd6) begin
        e = '0; e.busy = 1'b1; e.en = 16'h0040; e.din = sp + 16'd2;
        exp_q.push_back(e);
      end
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1;
    exp_q.push_back(e);
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exq);
    tests_run++;
    if (act !== exq) begin
      tests_failed++;
      $display("[TB] FAIL %s @cyc %0d: got req=%b we=%b addr=%h wd=%h en=%h din=%h selh=%b busy=%b done=%b err=%b, expected req=%b we=%b addr=%h wd=%h en=%h din=%h selh=%b busy=%b done=%b err=%b",
               name, cyc, act.req, act.we, act.addr, act.wdata, act.en, act.din, act.selh, act.busy, act.done, act.err,
               exq.req, exq.we, exq.addr, exq.wdata, exq.en, exq.din, exq.selh, exq.busy, exq.done, exq.err);
    end
  endtask

  task automatic checkLiteral(input string name, input logic [15:0] act, input logic [15:0] exq);
    tests_run++;
    if (act !== exq) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exq);
    end
  endtask

  // Every cycle, DUT outputs are compared against the model's next prediction (idle when none).
  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    a = sample();
    if (cyc < 8192) hist[cyc] = a;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : obs_t'('0);
    checkOutput("cycle", a, e);
    cyc++;
  end

  // Called at posedge+1 of an idle cycle; returns at posedge+1 of the next idle cycle.
  task automatic applyStimulus(input logic o, input logic [2:0] r, input logic [15:0] d,
                               input logic [15:0] sp, input int w, input logic [15:0] rd,
                               input bit noise, output int t0);
    int n;
    t0        = cyc;
    start     = 1'b1;
    op        = o;
    reg_sel   = r;
    push_data = d;
    sp_in     = sp;
    mem_ack   = 1'b0;
    buildTrace(o, r, d, sp, w, rd);
    n = exp_q.size();
    @(posedge clk); #1;
    for (int k = 1; k < n; k++) begin
      mem_ack   = (w < TO) && (k - 1 == w);
      mem_rdata = mem_ack ? rd : 16'($urandom);
      if (noise) begin
        start     = 1'($urandom);
        op        = 1'($urandom);
        reg_sel   = 3'($urandom);
        push_data = 16'($urandom);
        sp_in     = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start   = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic applyReset();
    buildTrace(1'b1, 3'd2, 16'h0000, 16'h3000, 99, 16'h0000);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    start = 1'b1; op = 1'b1; reg_sel = 3'd2; sp_in = 16'h3000; mem_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkLiteral("rst_async_req", {15'd0, mem_req}, 16'h0000);
    checkLiteral("rst_async_busy", {15'd0, busy}, 16'h0000);
    checkLiteral("rst_async_addr", mem_addr, 16'h0000);
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    reset = 1'b1; start = 1'b0; op = 1'b0; reg_sel = 3'd0;
    push_data = 16'h0000; sp_in = 16'h0000; mem_ack = 1'b0; mem_rdata = 16'h0000;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checkLiteral("reset_en_write", en_write, 16'h0000);

    applyStimulus(1'b0, 3'd0, 16'h1234, 16'h0100, 0, 16'h0000, 1'b0, t);
    checkLiteral("push_ax_addr", hist[t+1].addr, 16'h00FE);
    checkLiteral("push_ax_wdata", hist[t+1].wdata, 16'h1234);
    checkLiteral("push_ax_en", hist[t+2].en, 16'h0040);
    checkLiteral("push_ax_din", hist[t+2].din, 16'h00FE);
    checkLiteral("push_ax_done", {14'd0, hist[t+3].done, hist[t+3].err}, 16'h0002);

    applyStimulus(1'b1, 3'd1, 16'h0000, 16'h00FE, 3, 16'hBEEF, 1'b0, t);
    checkLiteral("pop_bx_addr", hist[t+1].addr, 16'h00FE);
    checkLiteral("pop_bx_en_reg", hist[t+5].en, 16'h0002);
    checkLiteral("pop_bx_din_reg", hist[t+5].din, 16'hBEEF);
    checkLiteral("pop_bx_en_sp", hist[t+6].en, 16'h0040);
    checkLiteral("pop_bx_din_sp", hist[t+6].din, 16'h0100);
    checkLiteral("pop_bx_done", {14'd0, hist[t+7].done, hist[t+7].err}, 16'h0002);

    applyStimulus(1'b0, 3'd3, 16'h5555, 16'h0000, 0, 16'h0000, 1'b0, t);
    checkLiteral("wrap_push_addr", hist[t+1].addr, 16'hFFFE);
    checkLiteral("wrap_push_sp", hist[t+2].din, 16'hFFFE);

    applyStimulus(1'b1, 3'd0, 16'h0000, 16'hFFFE, 0, 16'h7777, 1'b0, t);
    checkLiteral("wrap_pop_sp", hist[t+3].din, 16'h0000);

    applyStimulus(1'b0, 3'd6, 16'hAAAA, 16'h0200, 1, 16'h0000, 1'b0, t);
    checkLiteral("push_sp_wdata", hist[t+1].wdata, 16'h01FE);

    applyStimulus(1'b1, 3'd6, 16'h0000, 16'h0300, 0, 16'h4000, 1'b0, t);
    checkLiteral("pop_sp_en", hist[t+2].en, 16'h0040);
    checkLiteral("pop_sp_din", hist[t+2].din, 16'h4000);
    checkLiteral("pop_sp_done_no_wbsp", {hist[t+3].en[14:0], hist[t+3].done}, 16'h0001);

    applyStimulus(1'b0, 3'd2, 16'h9999, 16'h1000, 99, 16'h0000, 1'b1, t);
    checkLiteral("timeout_req_last", {15'd0, hist[t+4].req}, 16'h0001);
    checkLiteral("timeout_req_drop", {15'd0, hist[t+5].req}, 16'h0000);
    checkLiteral("timeout_done_err", {14'd0, hist[t+5].done, hist[t+5].err}, 16'h0003);

    applyReset();

    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 5)), 16'($urandom), 1'b1, t);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
